// File: rtl/axil_slave_regs.sv
`timescale 1ns/1ps
// axil_slave_regs
//   AXI4-Lite slave register bank. Registers 0..NUM_REGS-2 are read/write,
//   register NUM_REGS-1 is a read-only hardware status word fed by status_i.
//   The write path and the read path are independent FSMs and may run concurrently.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   W_IDLE | collecting AW and W (any order); commit once both are held
//   W_RESP | BVALID/BRESP held until BREADY
//   R_IDLE | ARREADY high, waiting for a read address
//   R_DATA | RVALID/RDATA held until RREADY
//
// Ports
//   AXI_ACLK, AXI_ARESET         clock, asynchronous active-high reset
//   AXI_AW*/AXI_W*/AXI_B*        write address, write data, write response channels
//   AXI_AR*/AXI_R*               read address, read data channels
//   ctrl_o                       live copy of register 0
//   status_i                     status word seen through register NUM_REGS-1
module axil_slave_regs #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 8,
    parameter int NUM_REGS         = 16
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESET,
    input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_AWADDR,
    input  logic                        AXI_AWVALID,
    output logic                        AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] AXI_WDATA,
    input  logic                        AXI_WVALID,
    output logic                        AXI_WREADY,
    output logic [1:0]                  AXI_BRESP,
    output logic                        AXI_BVALID,
    input  logic                        AXI_BREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
    input  logic                        AXI_ARVALID,
    output logic                        AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA,
    output logic                        AXI_RVALID,
    input  logic                        AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] ctrl_o,
    input  logic [C_AXI_DATA_WIDTH-1:0] status_i
);

    localparam int IW = C_AXI_ADDR_WIDTH - 2;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int NRW = NUM_REGS - 1;

    // One extra bit so NUM_REGS == 2**IW still compares correctly.
    localparam logic [IW:0] STATUS_IDX = (IW+1)'(NUM_REGS - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t        w_state_q;
    r_state_t        r_state_q;

    logic [DW-1:0]   regs_q [NRW];

    logic            awready_q;
    logic            wready_q;
    logic            aw_got_q;
    logic            w_got_q;
    logic [IW-1:0]   aw_idx_q;
    logic [DW-1:0]   wdata_q;
    logic            bvalid_q;
    logic [1:0]      bresp_q;

    logic            arready_q;
    logic            rvalid_q;
    logic [DW-1:0]   rdata_q;
    logic [DW-1:0]   rdata_d;

    logic [IW-1:0]   ar_idx;
    logic            wr_ok;
    logic            unused_addr_lsbs;

    assign ar_idx = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];
    assign wr_ok  = ({1'b0, aw_idx_q} < STATUS_IDX);

    // Byte-lane bits are meaningless for full-word registers.
    assign unused_addr_lsbs = ^{AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

    // Status is taken straight from status_i so a read returns the value
    // present on the AR handshake edge.
    always_comb begin
        rdata_d = '0;
        if ({1'b0, ar_idx} == STATUS_IDX) begin
            rdata_d = status_i;
        end
        for (int i = 0; i < NRW; i++) begin
            if ({1'b0, ar_idx} == (IW+1)'(i)) begin
                rdata_d = regs_q[i];
            end
        end
    end

    // Write path: AW and W are latched independently; the commit edge follows
    // the later of the two, so BVALID appears one cycle after it.
    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            for (int i = 0; i < NRW; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (awready_q && AXI_AWVALID) begin
                        aw_got_q  <= 1'b1;
                        aw_idx_q  <= AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
                        awready_q <= 1'b0;
                    end else if (!aw_got_q) begin
                        awready_q <= 1'b1;
                    end

                    if (wready_q && AXI_WVALID) begin
                        w_got_q  <= 1'b1;
                        wdata_q  <= AXI_WDATA;
                        wready_q <= 1'b0;
                    end else if (!w_got_q) begin
                        wready_q <= 1'b1;
                    end

                    if (aw_got_q && w_got_q) begin
                        for (int i = 0; i < NRW; i++) begin
                            if (wr_ok && (aw_idx_q == IW'(i))) begin
                                regs_q[i] <= wdata_q;
                            end
                        end
                        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        bvalid_q  <= 1'b1;
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arready_q && AXI_ARVALID) begin
                        rdata_q   <= rdata_d;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign AXI_AWREADY = awready_q;
    assign AXI_WREADY  = wready_q;
    assign AXI_BVALID  = bvalid_q;
    assign AXI_BRESP   = bresp_q;
    assign AXI_ARREADY = arready_q;
    assign AXI_RVALID  = rvalid_q;
    assign AXI_RDATA   = rdata_q;
    assign ctrl_o      = regs_q[0];

endmodule
